lifo_stack: RTL and testbench
=============================

Name: lifo_stack

Overview:
- Parametrised LIFO for the brainfuck core's loop-address stack. Successor to the single-pointer RAM stack.
- Adds depth, count and full/empty reporting, sticky overflow/underflow errors, simultaneous push+pop (replace-top), a synchronous flush and a zero-latency registered top-of-stack.
- Sits between the instruction decoder (push on '[', pop on matching ']') and the program-counter mux, which reads dataOut.

Parameters:
- addrSize, 9, log2 of depth; DEPTH = 2**addrSize entries.
- contentSize, 8, entry width in bits.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush; empties the stack and clears the error flags.
- dataIn  in  contentSize  value to push.
- push  in  1  push request.
- pop  in  1  pop request.
- dataOut  out  contentSize  current top of stack (registered).
- count  out  addrSize+1  number of stored entries, 0..DEPTH.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.
- overflow  out  1  sticky; a push was rejected.
- underflow  out  1  sticky; a pop was rejected.

Behaviour:
- Storage:
  - tos register holds the top entry.
  - mem[0..DEPTH-2] holds the entries below it (register array, async read). mem holds DEPTH-1 entries; together with tos, capacity is DEPTH.
- Reset (reset==0, async): count=0, tos=0, overflow=0, underflow=0. mem is not cleared. dataOut=0, empty=1, full=0.
- Priority each posedge: clear > push/pop. If clear=1: count=0, tos=0, overflow=0, underflow=0; push and pop are ignored.
- Push only, not full:
  - If count>0, mem[count-1]<=tos (spill).
  - tos<=dataIn; count+1.
- Push only, full: no state change; overflow<=1.
- Pop only, count>1: tos<=mem[count-2]; count-1.
- Pop only, count==1: tos<=0; count<=0.
- Pop only, empty: no state change; underflow<=1.
- Push+pop, count>=1 (including full): replace top. tos<=dataIn; count and mem unchanged; no error.
- Push+pop, empty: performs the push (tos<=dataIn, count=1); underflow<=1.
- Latency: dataOut and count reflect an operation on the cycle after the clock edge. There is no read latency beyond that.
- empty and full are combinational decodes of count.
- Error flags are sticky until reset or clear.
- Pointer wrap: count saturates by rule and never wraps. mem index arithmetic uses addrSize bits.
- Reset asserted mid-operation dominates immediately, independent of clk.

Optional Feature:
- Macro: LIFO_WATERMARK_EN.
- When defined:
  - Adds output highWater [addrSize+1].
  - highWater holds the maximum count reached since reset or clear, updated on the same edge as count.
  - Reset and clear set it to 0.
- When undefined: the port and its register are absent. All other behaviour is identical.

Test Plan (addrSize=2, DEPTH=4, contentSize=8):
- Reset then idle -> count=0, empty=1, full=0, dataOut=0x00, overflow=0, underflow=0.
- Push 0x11,0x22,0x33,0x44 on consecutive cycles -> full=1, count=4, dataOut=0x44. Pops on the next 4 cycles -> dataOut 0x33,0x22,0x11,0x00; empty=1 after the last pop.
- Fill to 4, push 0x55 -> count stays 4, dataOut=0x44, overflow=1. Then pop -> dataOut=0x33; overflow stays 1.
- Push 0x11, then push+pop 0x99 in one cycle -> count=1, dataOut=0x99. Push+pop while empty with 0x77 -> count=1, dataOut=0x77, underflow=1.
- Push 0x11,0x22, then clear asserted together with push=1 -> count=0, empty=1, both flags 0, dataOut=0x00.
- Push 3 entries, drop reset low between clock edges -> count=0 and dataOut=0 before the next posedge. With LIFO_WATERMARK_EN: highWater=3 before the reset and 0 after it.

Source files
------------

// File: rtl/lifo_stack.sv
// lifo_stack: parametrised LIFO holding the brainfuck core's loop addresses.
// The top entry lives in a dedicated register (tos) so dataOut is registered
// with no read latency. The entries below it sit in a register array (mem)
// with asynchronous read. Overflow and underflow are sticky error flags.
// Optional feature: define LIFO_WATERMARK_EN to add the highWater output,
// which tracks the largest count seen since reset or clear.
module lifo_stack #(
  parameter int addrSize    = 9,
  parameter int contentSize = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic [contentSize-1:0] dataIn,
  input  logic                   push,
  input  logic                   pop,
  output logic [contentSize-1:0] dataOut,
  output logic [addrSize:0]      count,
  output logic                   empty,
  output logic                   full,
  output logic                   overflow,
  output logic                   underflow
`ifdef LIFO_WATERMARK_EN
  ,
  output logic [addrSize:0]      highWater
`endif
);

  localparam int DEPTH = 2 ** addrSize;
  localparam logic [addrSize:0]   CNT_ONE   = (addrSize + 1)'(1);
  localparam logic [addrSize:0]   CNT_DEPTH = (addrSize + 1)'(DEPTH);
  localparam logic [addrSize-1:0] IDX_ONE   = addrSize'(1);
  localparam logic [addrSize-1:0] IDX_TWO   = addrSize'(2);

  logic [contentSize-1:0] mem [0:DEPTH-2];
  logic [contentSize-1:0] tos;
  logic [contentSize-1:0] tos_next;
  logic [addrSize:0]      count_next;
  logic                   ovf_next;
  logic                   unf_next;
  logic                   spill_en;
  logic [addrSize-1:0]    spill_idx;
  logic [addrSize-1:0]    pop_idx;

  // Below-top slots are addressed with addrSize-bit arithmetic. When the
  // stack is full the low bits of count wrap to zero, and count-2 still
  // lands on the last mem slot.
  assign spill_idx = count[addrSize-1:0] - IDX_ONE;
  assign pop_idx   = count[addrSize-1:0] - IDX_TWO;

  assign dataOut = tos;
  assign empty   = (count == '0);
  assign full    = (count == CNT_DEPTH);

  // Next-state decode: clear wins, then push+pop (replace top), push, pop.
  always_comb begin
    count_next = count;
    tos_next   = tos;
    ovf_next   = overflow;
    unf_next   = underflow;
    spill_en   = 1'b0;
    if (clear) begin
      count_next = '0;
      tos_next   = '0;
      ovf_next   = 1'b0;
      unf_next   = 1'b0;
    end else if (push && pop) begin
      tos_next = dataIn;
      if (empty) begin
        count_next = CNT_ONE;
        unf_next   = 1'b1;
      end
    end else if (push) begin
      if (full) begin
        ovf_next = 1'b1;
      end else begin
        spill_en   = !empty;
        tos_next   = dataIn;
        count_next = count + CNT_ONE;
      end
    end else if (pop) begin
      if (empty) begin
        unf_next = 1'b1;
      end else if (count == CNT_ONE) begin
        tos_next   = '0;
        count_next = '0;
      end else begin
        tos_next   = mem[pop_idx];
        count_next = count - CNT_ONE;
      end
    end
  end

  // Control and top-of-stack registers; reset is asynchronous and active-low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count     <= '0;
      tos       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count     <= count_next;
      tos       <= tos_next;
      overflow  <= ovf_next;
      underflow <= unf_next;
    end
  end

  // Spill the old top into the array when a new entry is pushed over it.
  always_ff @(posedge clk) begin
    if (spill_en) begin
      mem[spill_idx] <= tos;
    end
  end

`ifdef LIFO_WATERMARK_EN
  // Track the deepest the stack has been since the last reset or clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      highWater <= '0;
    end else if (clear) begin
      highWater <= '0;
    end else if (count_next > highWater) begin
      highWater <= count_next;
    end
  end
`endif

endmodule

// File: tb/tb_lifo_stack.sv
// tb_lifo_stack: directed and randomized checks of lifo_stack (DEPTH=4, 8-bit).
// The reference model is a queue of entries plus sticky flags.
// With LIFO_WATERMARK_EN defined, highWater is checked as well.
module tb_lifo_stack;

  localparam int AW = 2;
  localparam int DW = 8;
  localparam int DEPTH = 4;

  logic          clk;
  logic          reset;
  logic          clear;
  logic [DW-1:0] dataIn;
  logic          push;
  logic          pop;
  logic [DW-1:0] dataOut;
  logic [AW:0]   count;
  logic          empty;
  logic          full;
  logic          overflow;
  logic          underflow;
`ifdef LIFO_WATERMARK_EN
  logic [AW:0]   highWater;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] mq[$];
  logic          m_ovf;
  logic          m_unf;
  int            m_hw;

  lifo_stack #(.addrSize(AW), .contentSize(DW)) dut (
    .clk(clk),
    .reset(reset),
    .clear(clear),
    .dataIn(dataIn),
    .push(push),
    .pop(pop),
    .dataOut(dataOut),
    .count(count),
    .empty(empty),
    .full(full),
    .overflow(overflow),
    .underflow(underflow)
`ifdef LIFO_WATERMARK_EN
    ,
    .highWater(highWater)
`endif
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of inputs, sample 1 time unit after the edge, then idle.
  task automatic apply_stimulus(input logic c, input logic pu, input logic po,
                                input logic [DW-1:0] d);
    clear  = c;
    push   = pu;
    pop    = po;
    dataIn = d;
    @(posedge clk);
    #1;
    clear  = 1'b0;
    push   = 1'b0;
    pop    = 1'b0;
    dataIn = '0;
  endtask

  // Reference model: applies the stack rules to a queue.
  task automatic model_step(input logic c, input logic pu, input logic po,
                            input logic [DW-1:0] d);
    if (c) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_hw  = 0;
    end else if (pu && po) begin
      if (mq.size() == 0) begin
        mq.push_back(d);
        m_unf = 1'b1;
      end else begin
        mq[mq.size()-1] = d;
      end
    end else if (pu) begin
      if (mq.size() == DEPTH) m_ovf = 1'b1;
      else mq.push_back(d);
    end else if (po) begin
      if (mq.size() == 0) m_unf = 1'b1;
      else void'(mq.pop_back());
    end
    if (mq.size() > m_hw) m_hw = mq.size();
  endtask

  task automatic test_reset();
    reset  = 1'b0;
    clear  = 1'b0;
    push   = 1'b0;
    pop    = 1'b0;
    dataIn = '0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00);
    n_checks++;
    if ({count, empty, full, dataOut, overflow, underflow} !== {3'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      n_errors++;
      $display("[TB] FAIL reset_state: got count=%0d empty=%b full=%b dout=%h ovf=%b unf=%b, expected 0 1 0 00 0 0",
               count, empty, full, dataOut, overflow, underflow);
    end
  endtask

  task automatic test_fill_drain();
    logic [DW-1:0] exp_pop [4];
    exp_pop = '{8'h33, 8'h22, 8'h11, 8'h00};
    apply_stimulus(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 1; i <= 4; i++) begin
      apply_stimulus(1'b0, 1'b1, 1'b0, DW'(i * 8'h11));
      n_checks++;
      if (count !== 3'(i) || dataOut !== DW'(i * 8'h11)) begin
        n_errors++;
        $display("[TB] FAIL fill_push%0d: got count=%0d dout=%h, expected %0d %h", i, count, dataOut, i, DW'(i * 8'h11));
      end
    end
    n_checks++;
    if (full !== 1'b1 || empty !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL fill_full: got full=%b empty=%b, expected 1 0", full, empty);
    end
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b0, 1'b0, 1'b1, 8'h00);
      n_checks++;
      if (dataOut !== exp_pop[i] || count !== 3'(3 - i)) begin
        n_errors++;
        $display("[TB] FAIL drain_pop%0d: got dout=%h count=%0d, expected %h %0d", i, dataOut, count, exp_pop[i], 3 - i);
      end
    end
    n_checks++;
    if (empty !== 1'b1 || underflow !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL drain_empty: got empty=%b unf=%b, expected 1 0", empty, underflow);
    end
  endtask

  task automatic test_overflow();
    apply_stimulus(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 1; i <= 4; i++) apply_stimulus(1'b0, 1'b1, 1'b0, DW'(i * 8'h11));
    apply_stimulus(1'b0, 1'b1, 1'b0, 8'h55);
    n_checks++;
    if (count !== 3'd4 || dataOut !== 8'h44 || overflow !== 1'b1) begin
      n_errors++;
      $display("[TB] FAIL overflow_push: got count=%0d dout=%h ovf=%b, expected 4 44 1", count, dataOut, overflow);
    end
    apply_stimulus(1'b0, 1'b0, 1'b1, 8'h00);
    n_checks++;
    if (dataOut !== 8'h33 || overflow !== 1'b1 || count !== 3'd3) begin
      n_errors++;
      $display("[TB] FAIL overflow_sticky: got dout=%h ovf=%b count=%0d, expected 33 1 3", dataOut, overflow, count);
    end
  endtask

  task automatic test_replace();
    apply_stimulus(1'b1, 1'b0, 1'b0, 8'h00);
    apply_stimulus(1'b0, 1'b1, 1'b0, 8'h11);
    apply_stimulus(1'b0, 1'b1, 1'b1, 8'h99);
    n_checks++;
    if (count !== 3'd1 || dataOut !== 8'h99 || underflow !== 1'b0 || overflow !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL replace_top: got count=%0d dout=%h unf=%b ovf=%b, expected 1 99 0 0", count, dataOut, underflow, overflow);
    end
    apply_stimulus(1'b0, 1'b0, 1'b1, 8'h00);
    apply_stimulus(1'b0, 1'b1, 1'b1, 8'h77);
    n_checks++;
    if (count !== 3'd1 || dataOut !== 8'h77 || underflow !== 1'b1) begin
      n_errors++;
      $display("[TB] FAIL replace_empty: got count=%0d dout=%h unf=%b, expected 1 77 1", count, dataOut, underflow);
    end
  endtask

  task automatic test_clear();
    apply_stimulus(1'b1, 1'b0, 1'b0, 8'h00);
    apply_stimulus(1'b0, 1'b1, 1'b0, 8'h11);
    apply_stimulus(1'b0, 1'b1, 1'b0, 8'h22);
    apply_stimulus(1'b0, 1'b0, 1'b1, 8'h00);
    apply_stimulus(1'b0, 1'b0, 1'b1, 8'h00);
    apply_stimulus(1'b0, 1'b0, 1'b1, 8'h00);
    apply_stimulus(1'b0, 1'b1, 1'b0, 8'h11);
    apply_stimulus(1'b0, 1'b1, 1'b0, 8'h22);
    n_checks++;
    if (underflow !== 1'b1 || count !== 3'd2) begin
      n_errors++;
      $display("[TB] FAIL clear_setup: got unf=%b count=%0d, expected 1 2", underflow, count);
    end
    apply_stimulus(1'b1, 1'b1, 1'b0, 8'h66);
    n_checks++;
    if ({count, empty, overflow, underflow, dataOut} !== {3'd0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
      n_errors++;
      $display("[TB] FAIL clear_with_push: got count=%0d empty=%b ovf=%b unf=%b dout=%h, expected 0 1 0 0 00",
               count, empty, overflow, underflow, dataOut);
    end
  endtask

  task automatic test_async_reset();
    apply_stimulus(1'b1, 1'b0, 1'b0, 8'h00);
    apply_stimulus(1'b0, 1'b1, 1'b0, 8'hA1);
    apply_stimulus(1'b0, 1'b1, 1'b0, 8'hB2);
    apply_stimulus(1'b0, 1'b1, 1'b0, 8'hC3);
`ifdef LIFO_WATERMARK_EN
    n_checks++;
    if (highWater !== 3'd3) begin
      n_errors++;
      $display("[TB] FAIL hw_before_reset: got %0d, expected 3", highWater);
    end
`endif
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (count !== 3'd0 || dataOut !== 8'h00 || empty !== 1'b1) begin
      n_errors++;
      $display("[TB] FAIL async_reset: got count=%0d dout=%h empty=%b, expected 0 00 1", count, dataOut, empty);
    end
`ifdef LIFO_WATERMARK_EN
    n_checks++;
    if (highWater !== 3'd0) begin
      n_errors++;
      $display("[TB] FAIL hw_after_reset: got %0d, expected 0", highWater);
    end
`endif
    #2 reset = 1'b1;
  endtask

  task automatic test_random();
    logic          c;
    logic          pu;
    logic          po;
    logic [DW-1:0] d;
    logic [DW-1:0] exp_top;
    apply_stimulus(1'b1, 1'b0, 1'b0, 8'h00);
    model_step(1'b1, 1'b0, 1'b0, 8'h00);
    for (int n = 0; n < 400; n++) begin
      c  = ($urandom_range(0, 31) == 0);
      pu = ($urandom_range(0, 99) < 55);
      po = ($urandom_range(0, 99) < 45);
      d  = DW'($urandom);
      apply_stimulus(c, pu, po, d);
      model_step(c, pu, po, d);
      exp_top = (mq.size() > 0) ? mq[mq.size()-1] : 8'h00;
      n_checks++;
      if (count !== 3'(mq.size()) || dataOut !== exp_top || empty !== (mq.size() == 0) ||
          full !== (mq.size() == DEPTH) || overflow !== m_ovf || underflow !== m_unf) begin
        n_errors++;
        $display("[TB] FAIL random_%0d: got count=%0d dout=%h e=%b f=%b ovf=%b unf=%b, expected %0d %h %b %b %b %b",
                 n, count, dataOut, empty, full, overflow, underflow, mq.size(), exp_top,
                 mq.size() == 0, mq.size() == DEPTH, m_ovf, m_unf);
      end
`ifdef LIFO_WATERMARK_EN
      n_checks++;
      if (highWater !== 3'(m_hw)) begin
        n_errors++;
        $display("[TB] FAIL random_hw_%0d: got %0d, expected %0d", n, highWater, m_hw);
      end
`endif
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_hw  = 0;
    test_reset();
    test_fill_drain();
    test_overflow();
    test_replace();
    test_clear();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
